// File: rtl/fetch_stage.sv
// fetch_stage: stage 1 of the 3-stage pipeline.
// Owns the PC, drives the instruction cache and hands the fetched instruction
// and its PC to decode. It also handles global stall, redirects from stage 3
// and the bubble that follows reset.
//
// Ports
//   clk            in   clock; all state changes on the rising edge
//   reset          in   synchronous, active-low (0 = reset)
//   stall          in   global pipeline freeze
//   redirect_valid in   stage 3 branch/jump taken
//   redirect_pc    in   redirect target; the low two bits are dropped
//   icache_addr    out  fetch address presented this cycle
//   icache_re      out  icache read enable
//   icache_dout    in   word for the address presented last cycle
//   inst           out  instruction to decode
//   pc_out         out  PC of inst
//   inst_valid     out  inst is real (0 = bubble)
//   rs1, rs2       out  register file read indices sliced from inst
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic [31:0] icache_dout,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        stall_q, stall_d;
    logic [31:0] hold_q, hold_d;
    logic        squash;
    logic        live;

    // Redirect targets are word aligned, so the low bits are not used.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Next fetch address. Depends only on control inputs and pc_q, never on
    // icache_dout.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (!reset) begin
            pc_d = RESET_PC;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    assign icache_addr = pc_d;
    // The cache also reads during reset, so the reset-vector word is waiting
    // when reset releases.
    assign icache_re   = 1'b1;

    // A redirect is acted on only when the pipeline moves, and reset overrides it.
    assign squash = reset & redirect_valid & ~stall;

    // The first released cycle already holds the reset-vector word, which was
    // read while reset was low. It counts as live even though valid_q is still
    // clear.
    assign live = valid_q | reset;

    always_comb begin
        if (squash) begin
            inst = NOP_INST;
        end else if (stall_q) begin
            inst = hold_q;
        end else if (live) begin
            inst = icache_dout;
        end else begin
            inst = NOP_INST;
        end
    end

    assign pc_out     = pc_q;
    assign inst_valid = live & ~squash;
    assign rs1        = inst[19:15];
    assign rs2        = inst[24:20];

    always_comb begin
        valid_d = stall ? valid_q : 1'b1;
        stall_d = stall;
        hold_d  = hold_q;
        // Capture on entry to a stall. icache_dout may change while frozen.
        if (stall && !stall_q) begin
            hold_d = inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            hold_q  <= NOP_INST;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        junk;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .inst           (inst),
        .pc_out         (pc_out),
        .inst_valid     (inst_valid),
        .rs1            (rs1),
        .rs2            (rs2)
    );

    always #5 clk = ~clk;

    // Address-tagged instruction memory.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // One-cycle synchronous read model.
    always @(posedge clk) begin
        if (icache_re) icache_dout <= junk ? 32'hDEAD_BEEF : word(icache_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                           input logic [31:0] e_inst, input logic e_valid);
        chk({tag, "_addr"}, icache_addr, e_addr);
        chk({tag, "_pc"}, pc_out, e_pc);
        chk({tag, "_inst"}, inst, e_inst);
        chk({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, e_valid});
        chk({tag, "_rs1"}, {27'b0, rs1}, {27'b0, e_inst[19:15]});
        chk({tag, "_rs2"}, {27'b0, rs2}, {27'b0, e_inst[24:20]});
        chk({tag, "_re"}, {31'b0, icache_re}, 32'd1);
    endtask

    // Advance to just past the next rising edge.
    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        junk = 1'b0;

        // Reset held low for three cycles.
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            chk_cyc($sformatf("rst%0d", i), 32'h2000, 32'h2000, NOP, 1'b0);
        end

        // Release; free-run 0x2000..0x201C.
        reset = 1'b1;
        #1;
        chk_cyc("run0", 32'h2004, 32'h2000, word(32'h2000), 1'b1);
        for (int i = 1; i < 8; i++) begin
            nxt();
            #1;
            chk_cyc($sformatf("run%0d", i), 32'h2004 + 32'(4 * i), 32'h2000 + 32'(4 * i),
                    word(32'h2000 + 32'(4 * i)), 1'b1);
        end

        // Redirect to unaligned 0x2102 squashes the current instruction.
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h2102;
        #1;
        chk_cyc("redir_sq", 32'h2100, 32'h2020, NOP, 1'b0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk_cyc("redir_tgt", 32'h2104, 32'h2100, word(32'h2100), 1'b1);

        // Redirect back to 0x2008 for the stall test.
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h2008;
        #1;
        chk_cyc("to2008", 32'h2008, 32'h2104, NOP, 1'b0);

        // Three stall cycles while the cache returns junk.
        nxt();
        redirect_valid = 1'b0;
        stall = 1'b1;
        junk = 1'b1;
        #1;
        chk_cyc("stall0", 32'h2008, 32'h2008, word(32'h2008), 1'b1);
        nxt();
        #1;
        chk_cyc("stall1", 32'h2008, 32'h2008, word(32'h2008), 1'b1);
        nxt();
        #1;
        chk_cyc("stall2", 32'h2008, 32'h2008, word(32'h2008), 1'b1);
        nxt();
        stall = 1'b0;
        junk = 1'b0;
        #1;
        chk_cyc("unstall", 32'h200C, 32'h2008, word(32'h2008), 1'b1);
        nxt();
        #1;
        chk_cyc("after_stall", 32'h2010, 32'h200C, word(32'h200C), 1'b1);

        // Redirect during stall is ignored until stall drops.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h2200;
        #1;
        chk_cyc("rs_stall0", 32'h200C, 32'h200C, word(32'h200C), 1'b1);
        nxt();
        #1;
        chk_cyc("rs_stall1", 32'h200C, 32'h200C, word(32'h200C), 1'b1);
        nxt();
        stall = 1'b0;
        #1;
        chk_cyc("rs_take", 32'h2200, 32'h200C, NOP, 1'b0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk_cyc("rs_tgt", 32'h2204, 32'h2200, word(32'h2200), 1'b1);

        // Move to 0x2040, stall there, then assert reset mid-stall.
        redirect_valid = 1'b1;
        redirect_pc = 32'h2040;
        #1;
        chk_cyc("to2040", 32'h2040, 32'h2200, NOP, 1'b0);
        nxt();
        redirect_valid = 1'b0;
        stall = 1'b1;
        #1;
        chk_cyc("st2040", 32'h2040, 32'h2040, word(32'h2040), 1'b1);
        nxt();
        reset = 1'b0;
        #1;
        chk({"rst_stall", "_addr"}, icache_addr, 32'h2000);
        nxt();
        #1;
        chk_cyc("rst_after", 32'h2000, 32'h2000, NOP, 1'b0);
        nxt();
        reset = 1'b1;
        stall = 1'b0;
        #1;
        chk_cyc("rerun", 32'h2004, 32'h2000, word(32'h2000), 1'b1);

        // Address wraps past the top of memory.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        #1;
        chk({"wrap_redir", "_addr"}, icache_addr, 32'hFFFF_FFFC);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk_cyc("wrap", 32'h0000_0000, 32'hFFFF_FFFC, word(32'hFFFF_FFFC), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
